// File: rtl/issue_bundle_buffer_pkg.sv
// Shared types and constants for the issue bundle buffer and its neighbours.
// Slot storage width is fixed here; the top-level INSTR_W must match SLOT_INSTR_W.
package issue_bundle_buffer_pkg;

  localparam int SLOT_INSTR_W = 16;
  localparam int NUM_SLOTS    = 4;

  localparam logic [3:0] OPC_LOAD  = 4'b0010;
  localparam logic [3:0] OPC_STORE = 4'b0100;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  typedef struct packed {
    logic                    vld;
    logic [SLOT_INSTR_W-1:0] instr;
  } slot_t;

  function automatic logic is_mem_op(input logic [3:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/issue_bundle_buffer.sv
// Holds one 4-wide fetch bundle, presents pending slots to the load/store check,
// retires granted slots and accepts the next bundle on the edge the current one drains.
module issue_bundle_buffer
  import issue_bundle_buffer_pkg::*;
#(
  parameter int INSTR_W = SLOT_INSTR_W,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   fetch_valid,
  output logic                   fetch_ready,
  input  logic [NUM_SLOTS-1:0]   fetch_lane_vld,
  input  logic [4*INSTR_W-1:0]   fetch_instr,
  output logic [3:0]             op1,
  output logic [3:0]             op2,
  output logic [3:0]             op3,
  output logic [3:0]             op4,
  output logic                   ins1_history,
  output logic                   ins2_history,
  output logic                   ins3_history,
  output logic                   ins4_history,
  input  logic                   ins1_out,
  input  logic                   ins2_out,
  input  logic                   ins3_out,
  input  logic                   ins4_out,
  input  logic                   issue_stall,
  output logic [NUM_SLOTS-1:0]   disp_valid,
  output logic [4*INSTR_W-1:0]   disp_instr,
  output logic [CNT_W-1:0]       hold_cnt
);

  slot_t                slot_q [NUM_SLOTS];
  slot_t                slot_d [NUM_SLOTS];
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0] hist, grant, take, remain, hist_d;
  logic                 drain, load;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hist[i]                          = slot_q[i].vld;
      disp_instr[i*INSTR_W +: INSTR_W] = slot_q[i].instr;
    end
  end

  assign grant       = {ins4_out, ins3_out, ins2_out, ins1_out};
  assign take        = hist & grant & {NUM_SLOTS{~issue_stall & ~flush}};
  assign remain      = hist & ~take;
  assign drain       = (remain == '0);
  // Ready depends on this cycle's grants, so a bundle can load while its predecessor's last slots issue.
  assign fetch_ready = drain & ~flush;
  assign load        = fetch_valid & fetch_ready;

  assign disp_valid   = take;
  assign hold_cnt     = cnt_q;
  assign op1          = slot_q[0].instr[INSTR_W-1 -: 4];
  assign op2          = slot_q[1].instr[INSTR_W-1 -: 4];
  assign op3          = slot_q[2].instr[INSTR_W-1 -: 4];
  assign op4          = slot_q[3].instr[INSTR_W-1 -: 4];
  assign ins1_history = hist[0];
  assign ins2_history = hist[1];
  assign ins3_history = hist[2];
  assign ins4_history = hist[3];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves a latch behind.
    slot_d = slot_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < NUM_SLOTS; i++) slot_d[i].vld = remain[i];

    if (flush) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_d[i].vld = 1'b0;
      cnt_d = '0;
    end else if (load) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_d[i].vld   = fetch_lane_vld[i];
        slot_d[i].instr = fetch_instr[i*INSTR_W +: INSTR_W];
      end
      cnt_d = '0;
    end else if ((state_q == ST_HOLD) && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    for (int i = 0; i < NUM_SLOTS; i++) hist_d[i] = slot_d[i].vld;
    state_d = (hist_d != '0) ? ST_HOLD : ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
      // NOTE: slot storage is reset too, so instruction words read back as zero after reset.
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= slot_d[i];
    end
  end

endmodule
